fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter W, default 16: data word width in bits.
REQ-002 SHALL have parameter BURST, default 128: words per burst, which equals half the upstream FIFO chain depth; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, which is the FIFO chain read clock; every register is in this domain.
REQ-004 SHALL have port rst_, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port r_data, input, W bits: read data from the FIFO chain.
REQ-006 SHALL have port r_ready, input, 1 bit: FIFO chain has a word available.
REQ-007 SHALL have port r_ready_half, input, 1 bit: FIFO chain holds at least BURST words.
REQ-008 SHALL have port r_trigger, output, 1 bit: pop request to the FIFO chain.
REQ-009 SHALL have port out_data, output, W bits: downstream data.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port out_last, output, 1 bit: out_data is the final word of a burst.
REQ-013 SHALL have port err_underflow, output, 1 bit: sticky flag, FIFO chain ran dry mid-burst.
REQ-014 SHALL have port burst_count, output, 16 bits: number of completed bursts, wrapping.

Function
REQ-015 SHALL implement three states: IDLE, BURST, DONE.
REQ-016 In IDLE, when r_ready_half=1 the next state SHALL be BURST with remaining=BURST.
REQ-017 r_trigger SHALL be combinational: (state==BURST) && (!out_valid || out_ready).
REQ-018 A pop SHALL occur on an edge where r_trigger && r_ready; on that edge out_data<=r_data, out_valid<=1, and remaining decrements by 1.
REQ-019 out_last SHALL be registered with the popped word and SHALL be 1 only when remaining==1 at the pop.
REQ-020 When r_trigger=1 and no pop occurs, an edge with out_valid && out_ready SHALL clear out_valid.
REQ-021 Each accepted word SHALL reach the output one cycle after the pop, with sustained throughput of 1 word/cycle while out_ready=1 and r_ready=1.
REQ-022 out_valid, out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-023 In BURST, r_trigger=1 with r_ready=0 SHALL set err_underflow, which is cleared only by reset; the FSM stalls and resumes when r_ready returns, and no word is skipped or duplicated.
REQ-024 On the pop with remaining==1, the next state SHALL be DONE.
REQ-025 DONE SHALL last exactly one cycle, increment burst_count modulo 2^16, and return to IDLE.
REQ-026 A new burst SHALL begin no earlier than the cycle after DONE, and only if r_ready_half=1 is sampled in IDLE.
REQ-027 r_ready_half SHALL be ignored outside IDLE.
REQ-028 The remaining counter SHALL be 16 bits wide and SHALL never wrap below 1 while in BURST.

Reset
REQ-029 rst_=0 SHALL asynchronously force: state=IDLE, remaining=0, out_valid=0, out_data=0, out_last=0, err_underflow=0, burst_count=0; r_trigger therefore reads 0.
REQ-030 Reset mid-burst SHALL discard the in-flight word and the partial burst; the first burst after release starts fresh at word index 0.
REQ-031 Release of rst_ SHALL be synchronous to clk; this is the integrator's responsibility.

Structure
REQ-032 The state enum constants and the default BURST value SHALL reside in a shared package.
REQ-033 The output holding register (out_data, out_valid and out_last with stall hold) SHALL be a single sub-module named fifo_burst_outreg; the FSM, counters and flags SHALL remain in fifo_burst_reader.

Verification (W=16, BURST=4)
REQ-034 SHALL cover: FIFO data 0..7, r_ready_half=1, out_ready=1 -> outputs 0,1,2,3 with out_last on 3, then 4..7 with out_last on 7; burst_count=2; err_underflow=0.
REQ-035 SHALL cover: out_ready=0 for 3 cycles after the first word -> out_data holds at 0, r_trigger=0 during the stall, no word lost or duplicated.
REQ-036 SHALL cover: r_ready drops for 2 cycles after word 1 -> err_underflow=1 sticky; words 2,3 follow once r_ready returns; burst completes with out_last on 3.
REQ-037 SHALL cover: rst_ pulsed low after word 1 -> all outputs zero immediately; after release with fresh data 10..13 -> outputs 10..13 and burst_count=1.
REQ-038 SHALL cover: burst_count preloaded to 16'hFFFF via forced state, then one burst -> burst_count=0.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and
// the default burst length.
package fifo_burst_reader_pkg;

  // State constants carry an ST_ prefix so they never collide with the
  // BURST parameter of the reader.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Default burst length, equal to half of the upstream FIFO chain depth.
  localparam int BURST_DEFAULT = 128;

  // Width of the remaining-word and completed-burst counters.
  localparam int CNT_W = 16;

endpackage

// File: rtl/fifo_burst_outreg.sv
// Output holding register: captures a popped word and holds data, valid and
// last stable until the downstream side accepts it.
module fifo_burst_outreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last
);

  // Load on a pop, drop valid once the held word is accepted, else hold.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      // NOTE: out_data is a single datapath word, not a memory, so it is
      // reset along with the control bits and reads zero after reset.
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: waits until the FIFO chain holds a full burst, then pops
// BURST words into a stall-aware output register, flags underflow, and
// counts completed bursts.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int W     = 16,
  parameter int BURST = BURST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [W-1:0]     r_data,
  input  logic             r_ready,
  input  logic             r_ready_half,
  output logic             r_trigger,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             err_underflow,
  output logic [CNT_W-1:0] burst_count
);

  localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(BURST);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             pop;
  logic             pop_last;

  // Request a word whenever bursting and the output slot is free or draining.
  assign r_trigger = (state == ST_BURST) && (!out_valid || out_ready);
  assign pop       = r_trigger && r_ready;
  assign pop_last  = (remaining == CNT_W'(1));

  // Burst sequencing, remaining-word count, underflow flag and burst counter.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      err_underflow <= 1'b0;
      burst_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (r_ready_half) begin
            state     <= ST_BURST;
            remaining <= BURST_LEN;
          end
        end
        ST_BURST: begin
          // A wanted word that is not there stalls the burst and is remembered.
          if (r_trigger && !r_ready) begin
            err_underflow <= 1'b1;
          end
          if (pop) begin
            remaining <= remaining - CNT_W'(1);
            if (pop_last) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          burst_count <= burst_count + CNT_W'(1);
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fifo_burst_outreg #(
    .W(W)
  ) u_outreg (
    .clk       (clk),
    .rst_      (rst_),
    .load      (pop),
    .load_data (r_data),
    .load_last (pop_last),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader (W=16, BURST=4). The bench plays the FIFO
// chain, keeps a queue of expected (last, data) words derived from the order
// words were written, and checks every accepted transfer against it.
module tb_fifo_burst_reader;

  localparam int W     = 16;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst_;
  logic [W-1:0]  r_data;
  logic          r_ready;
  logic          r_ready_half;
  logic          r_trigger;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          err_underflow;
  logic [15:0]   burst_count;

  // FIFO chain model.
  logic [W-1:0]  fifo_mem [0:63];
  int            wr;
  int            rd;
  logic          ready_en;

  // Expected-output model and transfer log.
  logic [W:0]    exp_q [$];
  logic [W:0]    log_q [$];
  int            log_cyc [$];
  int            model_idx;
  int            cyc;

  int            checks;
  int            errors;

  logic          prev_stall;
  logic [W-1:0]  prev_data;
  logic          prev_last;

  always #5 clk = ~clk;

  assign r_data       = (rd < wr) ? fifo_mem[rd[5:0]] : '0;
  assign r_ready      = ready_en && (wr > rd);
  assign r_ready_half = ((wr - rd) >= BURST);

  fifo_burst_reader #(
    .W     (W),
    .BURST (BURST)
  ) dut (
    .clk           (clk),
    .rst_          (rst_),
    .r_data        (r_data),
    .r_ready       (r_ready),
    .r_ready_half  (r_ready_half),
    .r_trigger     (r_trigger),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .err_underflow (err_underflow),
    .burst_count   (burst_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Write one word into the FIFO chain and predict its position in a burst.
  task automatic load_word(input logic [W-1:0] d);
    logic lst;
    fifo_mem[wr[5:0]] = d;
    wr++;
    lst = ((model_idx % BURST) == (BURST - 1));
    exp_q.push_back({lst, d});
    model_idx++;
  endtask

  // Advance one clock; the FIFO read pointer follows any pop seen at the edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    pop = r_trigger && r_ready && rst_;
    @(posedge clk);
    #1;
    if (pop) rd++;
    cyc++;
  endtask

  // Run until every expected word has been delivered, bounded.
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      step();
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < 100), 32'd1);
    repeat (3) step();
  endtask

  // Step until out_valid with a given data word, bounded.
  task automatic wait_word(input string name, input logic [W-1:0] d);
    int n;
    n = 0;
    while (!(out_valid && out_data == d) && n < 50) begin
      step();
      n++;
    end
    check({name, "_word_seen"}, 32'(n < 50), 32'd1);
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  initial begin
    rst_       = 1'b0;
    ready_en   = 1'b1;
    out_ready  = 1'b1;
    wr         = 0;
    rd         = 0;
    model_idx  = 0;
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;

    fork
      begin : stim
        // Reset state.
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_r_trigger", 32'(r_trigger), 32'd0);
        check("rst_burst_count", 32'(burst_count), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        step();
        step();
        rst_ = 1'b1;

        // Two back-to-back bursts at full throughput.
        clear_log();
        for (int i = 0; i < 8; i++) load_word(W'(i));
        drain("t1");
        check("t1_burst_count", 32'(burst_count), 32'd2);
        check("t1_err", 32'(err_underflow), 32'd0);
        check("t1_log_size", 32'(log_q.size()), 32'd8);
        check("t1_word0", 32'(log_q[0]), 32'({1'b0, 16'd0}));
        check("t1_word3_last", 32'(log_q[3]), 32'({1'b1, 16'd3}));
        check("t1_word4", 32'(log_q[4]), 32'({1'b0, 16'd4}));
        check("t1_word7_last", 32'(log_q[7]), 32'({1'b1, 16'd7}));
        check("t1_rate_burst0", 32'(log_cyc[3] - log_cyc[0]), 32'd3);
        check("t1_rate_burst1", 32'(log_cyc[7] - log_cyc[4]), 32'd3);

        // Downstream stall for three cycles on the first word.
        clear_log();
        for (int i = 0; i < 4; i++) load_word(W'(i));
        wait_word("t2", W'(0));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          step();
          check("t2_stall_data", 32'(out_data), 32'd0);
          check("t2_stall_valid", 32'(out_valid), 32'd1);
          check("t2_stall_trigger", 32'(r_trigger), 32'd0);
        end
        out_ready = 1'b1;
        drain("t2");
        check("t2_log_size", 32'(log_q.size()), 32'd4);
        check("t2_word3_last", 32'(log_q[3]), 32'({1'b1, 16'd3}));
        check("t2_burst_count", 32'(burst_count), 32'd3);

        // FIFO runs dry for two cycles after word 1.
        clear_log();
        for (int i = 0; i < 4; i++) load_word(W'(i));
        wait_word("t3", W'(1));
        ready_en = 1'b0;
        step();
        check("t3_err_set", 32'(err_underflow), 32'd1);
        step();
        ready_en = 1'b1;
        drain("t3");
        check("t3_err_sticky", 32'(err_underflow), 32'd1);
        check("t3_log_size", 32'(log_q.size()), 32'd4);
        check("t3_word2", 32'(log_q[2]), 32'({1'b0, 16'd2}));
        check("t3_word3_last", 32'(log_q[3]), 32'({1'b1, 16'd3}));
        check("t3_burst_count", 32'(burst_count), 32'd4);

        // Reset mid-burst, then a fresh burst.
        clear_log();
        for (int i = 0; i < 4; i++) load_word(W'(i));
        wait_word("t4", W'(1));
        rst_ = 1'b0;
        #1;
        check("t4_rst_valid", 32'(out_valid), 32'd0);
        check("t4_rst_data", 32'(out_data), 32'd0);
        check("t4_rst_last", 32'(out_last), 32'd0);
        check("t4_rst_err", 32'(err_underflow), 32'd0);
        check("t4_rst_count", 32'(burst_count), 32'd0);
        check("t4_rst_trigger", 32'(r_trigger), 32'd0);
        exp_q.delete();
        rd        = wr;
        model_idx = 0;
        step();
        step();
        rst_ = 1'b1;
        clear_log();
        for (int i = 10; i < 14; i++) load_word(W'(i));
        drain("t4");
        check("t4_log_size", 32'(log_q.size()), 32'd4);
        check("t4_word0", 32'(log_q[0]), 32'({1'b0, 16'd10}));
        check("t4_word3_last", 32'(log_q[3]), 32'({1'b1, 16'd13}));
        check("t4_burst_count", 32'(burst_count), 32'd1);

        // Burst counter wraps from all-ones.
        force dut.burst_count = 16'hFFFF;
        step();
        release dut.burst_count;
        check("t5_preload", 32'(burst_count), 32'h0000_FFFF);
        clear_log();
        for (int i = 40; i < 44; i++) load_word(W'(i));
        drain("t5");
        check("t5_wrap", 32'(burst_count), 32'd0);
        check("t5_log_size", 32'(log_q.size()), 32'd4);
      end

      begin : compare
        logic [W:0] e;
        forever begin
          @(negedge clk);
          if (!rst_) begin
            prev_stall = 1'b0;
          end else begin
            if (prev_stall) begin
              check("hold_valid", 32'(out_valid), 32'd1);
              check("hold_data", 32'(out_data), 32'(prev_data));
              check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word actual=%0h required=none", out_data);
              end else begin
                e = exp_q.pop_front();
                check("xfer_data", 32'(out_data), 32'(e[W-1:0]));
                check("xfer_last", 32'(out_last), 32'(e[W]));
              end
              log_q.push_back({out_last, out_data});
              log_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
          end
        end
      end
    join_any
    disable fork;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
